// File: rtl/stepper_drive_ctrl_if.sv
// stepper_drive_ctrl_if: valid/ready move-command port of the stepper driver
interface stepper_drive_ctrl_if #(
  parameter int CNT_W = 16,
  parameter int DIV_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_dir;
  logic [CNT_W-1:0] cmd_steps;
  logic             half_step;
  logic [DIV_W-1:0] step_div;
  modport master (output cmd_valid, cmd_dir, cmd_steps, half_step, step_div, input cmd_ready);
  modport slave (input cmd_valid, cmd_dir, cmd_steps, half_step, step_div, output cmd_ready);
endinterface

// File: rtl/stepper_drive_ctrl.sv
// stepper_drive_ctrl: counted-move 4-coil stepper driver with abort, position and coil release
module stepper_drive_ctrl #(
  parameter int CNT_W       = 16,
  parameter int DIV_W       = 16,
  parameter int POS_W       = 24,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  stepper_drive_ctrl_if.slave  cmd,
  input  logic                 abort,
  output logic [3:0]           q,
  output logic                 step_tick,
  output logic                 busy,
  output logic                 done,
  output logic [POS_W-1:0]     position
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [31:0] HOLD = 32'(HOLD_CYCLES);
  localparam logic [3:0] PHASE [8] = '{4'h3, 4'h1, 4'h9, 4'h8, 4'hC, 4'h4, 4'h6, 4'h2};
  state_t           state, state_nx;
  logic [2:0]       idx, idx_nx, delta;
  logic [POS_W-1:0] pos_nx;
  logic [DIV_W-1:0] div_cnt, div_lat;
  logic [CNT_W-1:0] rem;
  logic [31:0]      idle_cnt;
  logic             dir_up, half_lat, released;
  logic             accept, motion, do_step, last, done_nx;
  always_comb begin
    accept   = state == IDLE && cmd.cmd_valid;
    motion   = (cmd.cmd_dir == 2'b01 || cmd.cmd_dir == 2'b10) && cmd.cmd_steps != '0;
    do_step  = state == RUN && !abort && div_cnt == '0;
    last     = do_step && rem == CNT_W'(1);
    state_nx = state == IDLE ? (accept && motion ? RUN : IDLE) : (abort || last ? IDLE : RUN);
    done_nx  = (accept && !motion) || (state == RUN && (abort || last));
    // full-step from an odd index moves one half-step to land back on the even phases
    delta    = half_lat || idx[0] ? 3'd1 : 3'd2;
    idx_nx   = dir_up ? idx + delta : idx - delta;
    pos_nx   = dir_up ? position + POS_W'(delta) : position - POS_W'(delta);
  end
  assign q             = released ? 4'h0 : PHASE[idx];
  assign busy          = state == RUN;
  assign cmd.cmd_ready = state == IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      position  <= '0;
      div_cnt   <= '0;
      div_lat   <= '0;
      rem       <= '0;
      idle_cnt  <= '0;
      dir_up    <= 1'b0;
      half_lat  <= 1'b0;
      released  <= 1'b0;
      step_tick <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      done      <= done_nx;
      step_tick <= do_step;
      if (accept) begin
        dir_up   <= cmd.cmd_dir == 2'b01;
        rem      <= cmd.cmd_steps;
        half_lat <= cmd.half_step;
        div_lat  <= cmd.step_div;
        div_cnt  <= cmd.step_div;
        idle_cnt <= '0;
      end else if (state == IDLE && idle_cnt != HOLD) begin
        idle_cnt <= idle_cnt + 32'd1;
      end
      if (state == IDLE && !accept && HOLD != 32'd0 && idle_cnt == HOLD - 32'd1)
        released <= 1'b1;
      if (state == RUN)
        div_cnt <= div_cnt == '0 ? div_lat : div_cnt - DIV_W'(1);
      if (do_step) begin
        idx      <= idx_nx;
        position <= pos_nx;
        rem      <= rem - CNT_W'(1);
        released <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_stepper_drive_ctrl.sv
// tb_stepper_drive_ctrl: directed spec scenarios plus random moves against a move-schedule model
module tb_stepper_drive_ctrl;
  localparam int HOLD = 10;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  q;
  logic        step_tick, busy, done;
  logic [23:0] position;
  int          n_pass = 0;
  int          n_chk = 0;
  logic [3:0]  ph [8] = '{4'h3, 4'h1, 4'h9, 4'h8, 4'hC, 4'h4, 4'h6, 4'h2};
  stepper_drive_ctrl_if #(.CNT_W(16), .DIV_W(16)) bus ();
  stepper_drive_ctrl #(.CNT_W(16), .DIV_W(16), .POS_W(24), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(bus), .abort(abort), .q(q), .step_tick(step_tick),
    .busy(busy), .done(done), .position(position)
  );
  always #5 clk = ~clk;
  // model: a move is a schedule of steps at accept + k*(step_div+1)
  int m_act = 0, m_idx = 0, m_pos = 0, m_en = 1, m_idle = 0, m_done = 0, m_tick = 0;
  int m_t0 = 0, m_n = 0, m_per = 1, m_taken = 0, m_sgn = 1, m_half = 0, m_d = 0, cyc = 0;
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_act = 0; m_idx = 0; m_pos = 0; m_en = 1; m_idle = 0; m_done = 0; m_tick = 0; cyc = 0;
    end else begin
      cyc++; m_done = 0; m_tick = 0;
      if (m_act == 0) begin
        if (bus.cmd_valid) begin
          m_idle = 0;
          if ((bus.cmd_dir == 2'd1 || bus.cmd_dir == 2'd2) && bus.cmd_steps != 0) begin
            m_act = 1; m_t0 = cyc; m_n = int'(bus.cmd_steps); m_per = int'(bus.step_div) + 1;
            m_taken = 0; m_sgn = bus.cmd_dir == 2'd1 ? 1 : -1; m_half = int'(bus.half_step);
          end else m_done = 1;
        end else begin
          m_idle++;
          if (m_idle == HOLD) m_en = 0;
        end
      end else if (abort) begin
        m_act = 0; m_done = 1;
      end else if (cyc - m_t0 == (m_taken + 1) * m_per) begin
        m_d = (m_half != 0 || m_idx % 2 == 1) ? 1 : 2;
        m_idx = (m_idx + m_sgn * m_d + 8) % 8;
        m_pos = m_pos + m_sgn * m_d;
        m_en = 1; m_tick = 1; m_taken++;
        if (m_taken == m_n) begin m_act = 0; m_done = 1; end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  always @(negedge clk) if (rst_n) begin
    chk("q", {28'd0, q}, {28'd0, m_en != 0 ? ph[m_idx] : 4'h0});
    chk("position", {8'd0, position}, {8'd0, 24'(m_pos)});
    chk("busy", {31'd0, busy}, 32'(m_act));
    chk("cmd_ready", {31'd0, bus.cmd_ready}, 32'(m_act == 0));
    chk("done", {31'd0, done}, 32'(m_done));
    chk("step_tick", {31'd0, step_tick}, 32'(m_tick));
  end
  task automatic send(input logic [1:0] d, input int s, input logic h, input int dv, input logic ab);
    chk("send_ready", {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_valid = 1'b1; bus.cmd_dir = d; bus.cmd_steps = 16'(s);
    bus.half_step = h; bus.step_div = 16'(dv); abort = ab;
    @(negedge clk);
    bus.cmd_valid = 1'b0; abort = 1'b0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  initial begin
    logic [3:0] t2q [8] = '{4'h2, 4'h6, 4'h4, 4'hC, 4'h8, 4'h9, 4'h1, 4'h3};
    logic [3:0] t1q [4] = '{4'h9, 4'hC, 4'h6, 4'h3};
    int cnt;
    bus.cmd_valid = 1'b0; bus.cmd_dir = 2'd0; bus.cmd_steps = '0; bus.half_step = 1'b0; bus.step_div = '0;
    @(negedge clk);
    #1 chk("reset_q", {28'd0, q}, 32'h3);
    chk("reset_pos", {8'd0, position}, 32'd0);
    do_reset();
    send(2'b01, 4, 1'b0, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_q", {28'd0, q}, {28'd0, t1q[k]});
    end
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_pos", {8'd0, position}, 32'd8);
    @(negedge clk);
    chk("t1_busy", {31'd0, busy}, 32'd0);
    do_reset();
    send(2'b10, 8, 1'b1, 2, 1'b0);
    repeat (2) @(negedge clk);
    chk("t2_early_tick", {31'd0, step_tick}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      if (k != 0) repeat (2) @(negedge clk);
      @(negedge clk);
      chk("t2_tick", {31'd0, step_tick}, 32'd1);
      chk("t2_q", {28'd0, q}, {28'd0, t2q[k]});
    end
    chk("t2_pos", {8'd0, position}, 32'h00FFFFF8);
    chk("t2_done", {31'd0, done}, 32'd1);
    do_reset();
    send(2'b01, 1, 1'b1, 0, 1'b0);
    @(negedge clk);
    chk("t3_half_q", {28'd0, q}, 32'h1);
    send(2'b01, 2, 1'b0, 0, 1'b0);
    @(negedge clk);
    chk("t3_snap_q", {28'd0, q}, 32'h9);
    @(negedge clk);
    chk("t3_q", {28'd0, q}, 32'hC);
    chk("t3_pos", {8'd0, position}, 32'd4);
    do_reset();
    send(2'b01, 100, 1'b0, 1, 1'b0);
    cnt = 0;
    for (int i = 0; i < 400 && cnt < 5; i++) begin
      @(negedge clk);
      if (step_tick) cnt++;
    end
    chk("t4_ticks", 32'(cnt), 32'd5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("t4_pos", {8'd0, position}, 32'd10);
    repeat (2) @(negedge clk);
    chk("t4_pos_hold", {8'd0, position}, 32'd10);
    send(2'b11, 50, 1'b0, 0, 1'b0);
    chk("t5_stop_done", {31'd0, done}, 32'd1);
    chk("t5_stop_q", {28'd0, q}, 32'h9);
    send(2'b01, 0, 1'b0, 0, 1'b0);
    chk("t5_zero_done", {31'd0, done}, 32'd1);
    chk("t5_zero_tick", {31'd0, step_tick}, 32'd0);
    send(2'b01, 1, 1'b0, 0, 1'b0);
    @(negedge clk);
    chk("t6_move_q", {28'd0, q}, 32'hC);
    repeat (9) @(negedge clk);
    chk("t6_still_held", {28'd0, q}, 32'hC);
    @(negedge clk);
    chk("t6_released", {28'd0, q}, 32'h0);
    send(2'b01, 1, 1'b0, 0, 1'b0);
    chk("t6_off_until_step", {28'd0, q}, 32'h0);
    @(negedge clk);
    chk("t6_reenergise", {28'd0, q}, 32'h6);
    send(2'b01, 100, 1'b0, 3, 1'b0);
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("t6_rst_q", {28'd0, q}, 32'h3);
    chk("t6_rst_pos", {8'd0, position}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 14)) begin
        abort = $urandom_range(0, 3) == 0;
        @(negedge clk);
      end
      abort = 1'b0;
      send(2'($urandom_range(0, 3)), $urandom_range(0, 10), 1'($urandom), $urandom_range(0, 3),
           1'($urandom_range(0, 5) == 0));
      for (int i = 0; i < 400 && !bus.cmd_ready; i++) begin
        abort = $urandom_range(0, 29) == 0;
        bus.half_step = 1'($urandom);
        bus.step_div = 16'($urandom_range(0, 3));
        @(negedge clk);
      end
      abort = 1'b0;
      chk("move_ends", {31'd0, bus.cmd_ready}, 32'd1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
